lcd_pixel_feeder: RTL and testbench
===================================

# lcd_pixel_feeder

Consumer end of the download queue. It pops the 17-bit token stream that the frame downloader writes into the pixel FIFO, checks the stream against the LCD controller's own frame and line timing, and returns one RGB565 pixel for each LCD pixel request. It sits between the queue's first-word-fall-through read port and the LCD timing generator. It also reports underflow and sync loss, and re-aligns on the next marker when either happens.

## Interface
- FRAME_WIDTH, 480, pixels per line expected from the stream and requested by the LCD
- FRAME_HEIGHT, 272, lines per frame
- UNDERFLOW_COLOR, 16'h0000, pixel value substituted when no valid pixel token is available
- clk  in  1  system clock
- reset_n  in  1  reset: one clock; reset is synchronous and active-low
- queue_data_i  in  17  queue head token (FWFT, valid while !queue_empty); tokens: 17'h10000 frame start, 17'h10001 line start, 17'h1FFFF frame end, bit16=0 pixel in [15:0]
- queue_empty  in  1  queue has no token
- queue_rd_en  out  1  pop head this cycle (combinational; never high while queue_empty or reset_n=0)
- lcd_frame_start  in  1  one-cycle pulse, start of LCD vertical period
- lcd_line_start  in  1  one-cycle pulse, start of an active line
- lcd_pixel_req  in  1  request one pixel this cycle (active area only)
- pixel_o  out  16  returned pixel
- pixel_valid  out  1  pixel_o valid
- frame_active  out  1  stream is locked to the current LCD frame
- sync_error  out  1  one-cycle pulse on stream/timing mismatch
- frame_done  out  1  one-cycle pulse when 17'h1FFFF is consumed
- underflow_count  out  16  substituted pixels in the current frame, saturating at 16'hFFFF

## Operation
- Head classes used below:
  - FS = 17'h10000 (frame start)
  - LS = 17'h10001 (line start)
  - FE = 17'h1FFFF (frame end)
  - PIX = bit16=0 (pixel)
- Counters:
  - row: 0..FRAME_HEIGHT
  - col: 0..FRAME_WIDTH
  - dirty flag: set when a line lost alignment
- SEEK_FRAME (reset state):
  - Pops every non-FS token, one per cycle.
  - Holds FS at the head without popping it.
  - If lcd_frame_start arrives while FS is at the head: pop FS, row=0, clear underflow_count, frame_active=1, go to WAIT_LINE.
  - If lcd_frame_start arrives with no FS at the head: that frame is missed and the block stays in SEEK_FRAME. No error is raised.
- WAIT_LINE, on lcd_line_start:
  - Head LS: pop it, col=0, dirty=0, go to LINE.
  - Queue empty: col=0, dirty=1, go to LINE.
  - Head PIX/FS/FE: sync_error, no pop, col=0, dirty=1, go to LINE.
- LINE, on each lcd_pixel_req:
  - Head PIX: pop it and return its [15:0].
  - Queue empty or any marker at the head: return UNDERFLOW_COLOR, no pop, underflow_count+1, dirty=1.
  - col increments on every request.
- End of a line (col reaches FRAME_WIDTH):
  - row+1.
  - If row==FRAME_HEIGHT, go to END.
  - Otherwise go to DRAIN if dirty, else WAIT_LINE.
- DRAIN:
  - Pops PIX tokens, one per cycle.
  - Head LS: go to WAIT_LINE (no pop).
  - Head FE or FS: sync_error, frame_active=0, go to SEEK_FRAME.
  - On lcd_line_start while still draining: treat as WAIT_LINE with an empty queue (line of UNDERFLOW_COLOR), stay misaligned.
- END:
  - Pops PIX tokens.
  - Head FE: pop it, frame_done, frame_active=0, go to SEEK_FRAME.
  - Head LS or FS: sync_error, frame_active=0, go to SEEK_FRAME (no pop).
- lcd_frame_start in any state other than SEEK_FRAME: sync_error, frame_active=0, go to SEEK_FRAME. The SEEK_FRAME rules apply from the next cycle.
- lcd_pixel_req outside LINE: answered with UNDERFLOW_COLOR, not counted, col unchanged.

## Timing
- Reset values (on the clk edge with reset_n=0):
  - pixel_o=0, pixel_valid=0, frame_active=0, sync_error=0, frame_done=0, underflow_count=0
  - state SEEK_FRAME, row=col=0
- Reset mid-frame drops lock immediately; the queue is not flushed by this block.
- Pixel latency: pixel_o and pixel_valid are registered and appear exactly 1 cycle after lcd_pixel_req. Back-to-back requests give back-to-back pixels.
- queue_rd_en is asserted in the same cycle the head is decoded. The next head is used the following cycle. At most one pop per cycle.
- sync_error and frame_done are registered one-cycle pulses, 1 cycle after the causing event.
- lcd_line_start and lcd_pixel_req in the same cycle: the line start is processed first, and the request is answered per the WAIT_LINE rule.

## Test plan
Benches use FRAME_WIDTH=4, FRAME_HEIGHT=2.
- Clean frame: queue preloaded with FS, LS, P1..P4, LS, P5..P8, FE; drive frame_start, 2 line_starts each followed by 4 pixel_reqs.
  - Expect pixels 1..8, each 1 cycle after its request.
  - Expect frame_done 1 cycle after FE is popped, underflow_count=0, no sync_error.
- Garbage before frame: queue holds P9, LS, FS, ...
  - Expect P9 and LS popped and discarded.
  - Expect FS held until frame_start, then the frame decodes normally.
- Underflow: line 0 has only P1,P2 before the queue goes empty for 3 cycles.
  - Expect P1, P2, then 0000, 0000; underflow_count=2.
  - Late-arriving P3,P4 are drained; line 1 is aligned on its LS.
- Premature marker: line 0 contains P1, LS, P5...
  - Expect P1 then 3× UNDERFLOW_COLOR with no pop of LS.
  - Expect line 1 to decode from that LS.
- Timing abort: frame_start pulsed mid line 1.
  - Expect sync_error, frame_active=0, return to SEEK_FRAME.
  - Expect the next FS+frame_start to relock.
- Reset: reset_n low mid-frame for 1 cycle.
  - Expect all outputs at reset values on the next cycle and state SEEK_FRAME.

Source files
------------

// File: rtl/lcd_pixel_feeder.sv
// lcd_pixel_feeder
// Consumer end of the frame download queue. Pops the 17-bit token stream
// from a first-word-fall-through FIFO, keeps it aligned with the LCD
// controller's frame/line timing and answers every LCD pixel request with
// one RGB565 pixel one cycle later. Missing pixels are replaced by
// UNDERFLOW_COLOR and counted; timing mismatches pulse sync_error and the
// block re-aligns on the next frame or line marker.
module lcd_pixel_feeder #(
    parameter int          FRAME_WIDTH     = 480,
    parameter int          FRAME_HEIGHT    = 272,
    parameter logic [15:0] UNDERFLOW_COLOR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [16:0] queue_data_i,
    input  logic        queue_empty,
    output logic        queue_rd_en,
    input  logic        lcd_frame_start,
    input  logic        lcd_line_start,
    input  logic        lcd_pixel_req,
    output logic [15:0] pixel_o,
    output logic        pixel_valid,
    output logic        frame_active,
    output logic        sync_error,
    output logic        frame_done,
    output logic [15:0] underflow_count
);

    localparam int COL_W = $clog2(FRAME_WIDTH + 1);
    localparam int ROW_W = $clog2(FRAME_HEIGHT + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_WIDTH);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_HEIGHT);

    // Stream marker encodings; any token with bit 16 clear is a pixel.
    localparam logic [16:0] TOK_FS = 17'h10000;
    localparam logic [16:0] TOK_LS = 17'h10001;
    localparam logic [16:0] TOK_FE = 17'h1FFFF;

    typedef enum logic [2:0] {
        ST_SEEK_FRAME = 3'd0,
        ST_WAIT_LINE  = 3'd1,
        ST_LINE       = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_END        = 3'd4
    } state_t;

    state_t           state_r;
    logic [ROW_W-1:0] row_r;
    logic [COL_W-1:0] col_r;
    logic             dirty_r;

    logic             head_fs_s;
    logic             head_ls_s;
    logic             head_fe_s;
    logic             head_pix_s;
    logic             head_other_s;
    logic             pop_s;
    logic [COL_W-1:0] col_inc_s;
    logic [ROW_W-1:0] row_inc_s;
    logic             line_end_s;
    logic             last_row_s;
    logic             timing_abort_s;

    // Saturating increment for the per-frame underflow counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Classify the queue head; every class is false while the queue is empty.
    always_comb begin
        head_fs_s    = 1'b0;
        head_ls_s    = 1'b0;
        head_fe_s    = 1'b0;
        head_pix_s   = 1'b0;
        head_other_s = 1'b0;
        if (!queue_empty) begin
            head_fs_s    = (queue_data_i == TOK_FS);
            head_ls_s    = (queue_data_i == TOK_LS);
            head_fe_s    = (queue_data_i == TOK_FE);
            head_pix_s   = ~queue_data_i[16];
            head_other_s = queue_data_i[16] & (queue_data_i != TOK_FS) &
                           (queue_data_i != TOK_LS) & (queue_data_i != TOK_FE);
        end else begin
            head_fs_s    = 1'b0;
        end
    end

    // Line/frame position helpers used at the end of each active line.
    always_comb begin
        col_inc_s      = col_r + COL_W'(1);
        row_inc_s      = row_r + ROW_W'(1);
        line_end_s     = (col_inc_s == COL_LAST);
        last_row_s     = (row_inc_s == ROW_LAST);
        timing_abort_s = lcd_frame_start & (state_r != ST_SEEK_FRAME);
    end

    // Pop decision for the current head; must be combinational so the FIFO
    // advances in the same cycle the head is decoded.
    always_comb begin
        pop_s = 1'b0;
        if (!reset_n) begin
            pop_s = 1'b0;
        end else if (timing_abort_s) begin
            pop_s = 1'b0;
        end else begin
            case (state_r)
                ST_SEEK_FRAME: begin
                    if (head_fs_s) begin
                        pop_s = lcd_frame_start;
                    end else begin
                        pop_s = ~queue_empty;
                    end
                end
                ST_WAIT_LINE: begin
                    if (lcd_line_start) begin
                        pop_s = head_ls_s;
                    end else begin
                        pop_s = 1'b0;
                    end
                end
                ST_LINE: begin
                    if (lcd_pixel_req) begin
                        pop_s = head_pix_s;
                    end else begin
                        pop_s = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (lcd_line_start) begin
                        pop_s = 1'b0;
                    end else begin
                        pop_s = head_pix_s | head_other_s;
                    end
                end
                ST_END: begin
                    pop_s = head_pix_s | head_fe_s | head_other_s;
                end
                default: begin
                    pop_s = 1'b0;
                end
            endcase
        end
    end

    assign queue_rd_en = pop_s;

    // Stream alignment state machine with registered pixel and status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r         <= ST_SEEK_FRAME;
            row_r           <= '0;
            col_r           <= '0;
            dirty_r         <= 1'b0;
            pixel_o         <= 16'h0000;
            pixel_valid     <= 1'b0;
            frame_active    <= 1'b0;
            sync_error      <= 1'b0;
            frame_done      <= 1'b0;
            underflow_count <= 16'h0000;
        end else begin
            sync_error  <= 1'b0;
            frame_done  <= 1'b0;
            pixel_valid <= lcd_pixel_req;
            if (lcd_pixel_req) begin
                pixel_o <= UNDERFLOW_COLOR;
            end
            if (timing_abort_s) begin
                sync_error   <= 1'b1;
                frame_active <= 1'b0;
                state_r      <= ST_SEEK_FRAME;
            end else begin
                case (state_r)
                    ST_SEEK_FRAME: begin
                        if (head_fs_s && lcd_frame_start) begin
                            row_r           <= '0;
                            col_r           <= '0;
                            underflow_count <= 16'h0000;
                            frame_active    <= 1'b1;
                            state_r         <= ST_WAIT_LINE;
                        end
                    end
                    ST_WAIT_LINE: begin
                        if (lcd_line_start) begin
                            col_r   <= '0;
                            state_r <= ST_LINE;
                            if (head_ls_s) begin
                                dirty_r <= 1'b0;
                            end else begin
                                // Empty queue is a silent underrun; a wrong
                                // token at the head is a real misalignment.
                                dirty_r    <= 1'b1;
                                sync_error <= ~queue_empty;
                            end
                        end
                    end
                    ST_LINE: begin
                        if (lcd_pixel_req) begin
                            col_r <= col_inc_s;
                            if (head_pix_s) begin
                                pixel_o <= queue_data_i[15:0];
                            end else begin
                                underflow_count <= sat_inc16(underflow_count);
                                dirty_r         <= 1'b1;
                            end
                            if (line_end_s) begin
                                row_r <= row_inc_s;
                                if (last_row_s) begin
                                    state_r <= ST_END;
                                end else if (dirty_r || !head_pix_s) begin
                                    state_r <= ST_DRAIN;
                                end else begin
                                    state_r <= ST_WAIT_LINE;
                                end
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (lcd_line_start) begin
                            // Still misaligned when the LCD starts a line:
                            // serve the whole line with the underflow colour.
                            col_r   <= '0;
                            dirty_r <= 1'b1;
                            state_r <= ST_LINE;
                        end else if (head_ls_s) begin
                            state_r <= ST_WAIT_LINE;
                        end else if (head_fe_s || head_fs_s) begin
                            sync_error   <= 1'b1;
                            frame_active <= 1'b0;
                            state_r      <= ST_SEEK_FRAME;
                        end
                    end
                    ST_END: begin
                        if (head_fe_s) begin
                            frame_done   <= 1'b1;
                            frame_active <= 1'b0;
                            state_r      <= ST_SEEK_FRAME;
                        end else if (head_ls_s || head_fs_s) begin
                            sync_error   <= 1'b1;
                            frame_active <= 1'b0;
                            state_r      <= ST_SEEK_FRAME;
                        end
                    end
                    default: begin
                        frame_active <= 1'b0;
                        state_r      <= ST_SEEK_FRAME;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_pixel_feeder.sv
// Bench for lcd_pixel_feeder with a 4x2 frame. A token queue stands in for
// the FIFO, a behavioural model predicts every output each cycle, and the
// scenarios also check literal pixel sequences and counter values.
module tb_lcd_pixel_feeder;

    localparam int W = 4;
    localparam int H = 2;
    localparam logic [16:0] FS = 17'h10000;
    localparam logic [16:0] LS = 17'h10001;
    localparam logic [16:0] FE = 17'h1FFFF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [16:0] queue_data_i;
    logic        queue_empty;
    logic        queue_rd_en;
    logic        lcd_frame_start;
    logic        lcd_line_start;
    logic        lcd_pixel_req;
    logic [15:0] pixel_o;
    logic        pixel_valid;
    logic        frame_active;
    logic        sync_error;
    logic        frame_done;
    logic [15:0] underflow_count;

    lcd_pixel_feeder #(
        .FRAME_WIDTH    (W),
        .FRAME_HEIGHT   (H),
        .UNDERFLOW_COLOR(16'h0000)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .queue_data_i   (queue_data_i),
        .queue_empty    (queue_empty),
        .queue_rd_en    (queue_rd_en),
        .lcd_frame_start(lcd_frame_start),
        .lcd_line_start (lcd_line_start),
        .lcd_pixel_req  (lcd_pixel_req),
        .pixel_o        (pixel_o),
        .pixel_valid    (pixel_valid),
        .frame_active   (frame_active),
        .sync_error     (sync_error),
        .frame_done     (frame_done),
        .underflow_count(underflow_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [16:0] tq[$];
    logic [15:0] got[$];
    logic [15:0] exp_px[$];
    int fd_cnt = 0;
    int se_cnt = 0;

    // Model state: phase 0 seek frame, 1 wait line, 2 in line, 3 drain, 4 end.
    int          m_ph, m_row, m_col, m_uc;
    bit          m_dirty, m_pv, m_fa, m_se, m_fd;
    logic [15:0] m_pix;
    int          n_ph, n_row, n_col, n_uc;
    bit          n_dirty, n_pv, n_fa, n_se, n_fd;
    logic [15:0] n_pix;
    bit          e_pop;
    bit          mvalid = 1'b0;
    bit          dut_pop;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual %0h required %0h", nm, $time, act, exp);
        end
    endtask

    task automatic refresh();
        queue_empty  = (tq.size() == 0);
        queue_data_i = (tq.size() == 0) ? 17'h00000 : tq[0];
    endtask

    task automatic push(input logic [16:0] t);
        tq.push_back(t);
        refresh();
    endtask

    // Spec rules applied to the current inputs and queue head.
    task automatic model_step();
        bit emp, fs, ls, fe, pix;
        logic [16:0] h;
        emp = (tq.size() == 0);
        h   = emp ? 17'h00000 : tq[0];
        fs  = !emp && (h == FS);
        ls  = !emp && (h == LS);
        fe  = !emp && (h == FE);
        pix = !emp && (h[16] == 1'b0);
        n_ph = m_ph; n_row = m_row; n_col = m_col; n_uc = m_uc;
        n_dirty = m_dirty; n_fa = m_fa; n_se = 1'b0; n_fd = 1'b0;
        n_pv = lcd_pixel_req;
        n_pix = lcd_pixel_req ? 16'h0000 : m_pix;
        e_pop = 1'b0;
        if (!reset_n) begin
            n_ph = 0; n_row = 0; n_col = 0; n_uc = 0; n_dirty = 1'b0;
            n_pix = 16'h0000; n_pv = 1'b0; n_fa = 1'b0;
        end else if (lcd_frame_start && m_ph != 0) begin
            n_se = 1'b1; n_fa = 1'b0; n_ph = 0;
        end else if (m_ph == 0) begin
            if (!emp && !fs) e_pop = 1'b1;
            if (fs && lcd_frame_start) begin
                e_pop = 1'b1; n_row = 0; n_uc = 0; n_fa = 1'b1; n_ph = 1;
            end
        end else if (m_ph == 1) begin
            if (lcd_line_start) begin
                n_col = 0; n_ph = 2;
                if (ls) begin
                    e_pop = 1'b1; n_dirty = 1'b0;
                end else begin
                    n_dirty = 1'b1; n_se = !emp;
                end
            end
        end else if (m_ph == 2) begin
            if (lcd_pixel_req) begin
                n_col = m_col + 1;
                if (pix) begin
                    e_pop = 1'b1; n_pix = h[15:0];
                end else begin
                    n_dirty = 1'b1;
                    if (n_uc < 65535) n_uc = n_uc + 1;
                end
                if (n_col == W) begin
                    n_row = m_row + 1;
                    n_ph = (n_row == H) ? 4 : (n_dirty ? 3 : 1);
                end
            end
        end else if (m_ph == 3) begin
            if (lcd_line_start) begin
                n_col = 0; n_dirty = 1'b1; n_ph = 2;
            end else if (pix) begin
                e_pop = 1'b1;
            end else if (ls) begin
                n_ph = 1;
            end else if (fe || fs) begin
                n_se = 1'b1; n_fa = 1'b0; n_ph = 0;
            end else if (!emp) begin
                e_pop = 1'b1;
            end
        end else begin
            if (pix) begin
                e_pop = 1'b1;
            end else if (fe) begin
                e_pop = 1'b1; n_fd = 1'b1; n_fa = 1'b0; n_ph = 0;
            end else if (ls || fs) begin
                n_se = 1'b1; n_fa = 1'b0; n_ph = 0;
            end else if (!emp) begin
                e_pop = 1'b1;
            end
        end
    endtask

    // Single compare process: check every output against the model between
    // edges, then advance the model and the FIFO on the clock edge.
    always begin
        @(negedge clk);
        model_step();
        if (mvalid) begin
            chk("queue_rd_en", queue_rd_en, e_pop);
            chk("pixel_valid", pixel_valid, m_pv);
            chk("pixel_o", pixel_o, m_pix);
            chk("frame_active", frame_active, m_fa);
            chk("sync_error", sync_error, m_se);
            chk("frame_done", frame_done, m_fd);
            chk("underflow_count", underflow_count, m_uc[15:0]);
            if (pixel_valid) got.push_back(pixel_o);
            if (frame_done) fd_cnt++;
            if (sync_error) se_cnt++;
        end
        dut_pop = queue_rd_en;
        @(posedge clk);
        if (!reset_n) mvalid = 1'b1;
        m_ph = n_ph; m_row = n_row; m_col = n_col; m_uc = n_uc;
        m_dirty = n_dirty; m_pv = n_pv; m_fa = n_fa; m_se = n_se; m_fd = n_fd;
        m_pix = n_pix;
        #1;
        if (dut_pop && tq.size() > 0) void'(tq.pop_front());
        refresh();
    end

    task automatic step(input bit fs, input bit ls, input bit req);
        lcd_frame_start = fs;
        lcd_line_start  = ls;
        lcd_pixel_req   = req;
        @(posedge clk);
        #1;
        lcd_frame_start = 1'b0;
        lcd_line_start  = 1'b0;
        lcd_pixel_req   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reqs(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic push_frame(input logic [15:0] base);
        push(FS); push(LS);
        for (int i = 0; i < 4; i++) push({1'b0, base + 16'(i)});
        push(LS);
        for (int i = 4; i < 8; i++) push({1'b0, base + 16'(i)});
        push(FE);
    endtask

    task automatic run_frame();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0); reqs(W);
        step(1'b0, 1'b1, 1'b0); reqs(W);
        idle(3);
    endtask

    task automatic exp_seq(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) exp_px.push_back(base + 16'(i));
    endtask

    task automatic chk_px(input string nm);
        chk({nm, "_count"}, got.size(), exp_px.size());
        for (int i = 0; i < exp_px.size(); i++) begin
            if (i < got.size()) chk(nm, got[i], exp_px[i]);
        end
        got.delete();
        exp_px.delete();
    endtask

    task automatic clear_counts();
        got.delete();
        fd_cnt = 0;
        se_cnt = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        lcd_frame_start = 1'b0;
        lcd_line_start  = 1'b0;
        lcd_pixel_req   = 1'b0;
        refresh();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Clean frame.
        clear_counts();
        push_frame(16'h0001);
        idle(2);
        #2;
        chk("clean_fs_held", queue_data_i, FS);
        run_frame();
        exp_seq(16'h0001, 8);
        chk_px("clean_px");
        chk("clean_done", fd_cnt, 1);
        chk("clean_serr", se_cnt, 0);
        chk("clean_uflow", underflow_count, 16'h0000);
        chk("clean_inactive", frame_active, 1'b0);
        chk("clean_empty", tq.size(), 0);

        // Garbage ahead of the frame start is discarded.
        clear_counts();
        push(17'h00009); push(LS);
        push_frame(16'h00A1);
        idle(4);
        #2;
        chk("garbage_head", queue_data_i, FS);
        chk("garbage_left", tq.size(), 12);
        run_frame();
        exp_seq(16'h00A1, 8);
        chk_px("garbage_px");
        chk("garbage_done", fd_cnt, 1);

        // Underflow in line 0, late pixels drained, line 1 realigned.
        clear_counts();
        push(FS); push(LS); push(17'h00011); push(17'h00012);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0); reqs(W);
        idle(3);
        chk("uflow_mid", underflow_count, 16'd2);
        push(17'h00013); push(17'h00014); push(LS);
        for (int i = 0; i < 4; i++) push({1'b0, 16'h0015 + 16'(i)});
        push(FE);
        idle(4);
        step(1'b0, 1'b1, 1'b0); reqs(W);
        idle(3);
        reqs(1);
        idle(2);
        exp_px.push_back(16'h0011); exp_px.push_back(16'h0012);
        exp_px.push_back(16'h0000); exp_px.push_back(16'h0000);
        exp_seq(16'h0015, 4);
        exp_px.push_back(16'h0000);
        chk_px("uflow_px");
        chk("uflow_count", underflow_count, 16'd2);
        chk("uflow_done", fd_cnt, 1);
        chk("uflow_serr", se_cnt, 0);

        // Premature line marker inside line 0.
        clear_counts();
        push(FS); push(LS); push(17'h00021); push(LS);
        for (int i = 0; i < 4; i++) push({1'b0, 16'h0025 + 16'(i)});
        push(FE);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0); reqs(W);
        idle(2);
        step(1'b0, 1'b1, 1'b0); reqs(W);
        idle(3);
        exp_px.push_back(16'h0021);
        exp_px.push_back(16'h0000); exp_px.push_back(16'h0000); exp_px.push_back(16'h0000);
        exp_seq(16'h0025, 4);
        chk_px("early_ls_px");
        chk("early_ls_count", underflow_count, 16'd3);
        chk("early_ls_done", fd_cnt, 1);
        chk("early_ls_serr", se_cnt, 0);

        // Frame start in the middle of line 1 aborts, then relock.
        clear_counts();
        push(FS); push(LS);
        for (int i = 0; i < 4; i++) push({1'b0, 16'h0031 + 16'(i)});
        push(LS); push(17'h00035); push(17'h00036);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0); reqs(W);
        chk("abort_active", frame_active, 1'b1);
        step(1'b0, 1'b1, 1'b0); reqs(2);
        step(1'b1, 1'b0, 1'b0);
        idle(1);
        chk("abort_serr", se_cnt, 1);
        chk("abort_inactive", frame_active, 1'b0);
        exp_seq(16'h0031, 6);
        chk_px("abort_px");
        push_frame(16'h0041);
        idle(2);
        run_frame();
        exp_seq(16'h0041, 8);
        chk_px("relock_px");
        chk("relock_done", fd_cnt, 1);
        chk("relock_serr", se_cnt, 1);

        // One-cycle reset mid-frame.
        clear_counts();
        push(FS); push(LS); push(17'h00051);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0); reqs(2);
        push(17'h00052); push(LS);
        lcd_pixel_req = 1'b1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        lcd_pixel_req = 1'b0;
        chk("rst_pixel_valid", pixel_valid, 1'b0);
        chk("rst_pixel_o", pixel_o, 16'h0000);
        chk("rst_frame_active", frame_active, 1'b0);
        chk("rst_uflow", underflow_count, 16'h0000);
        chk("rst_serr", sync_error, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        begin
            int budget;
            budget = 20;
            while (tq.size() != 0 && budget > 0) begin
                idle(1);
                budget--;
            end
            chk("rst_seek_flush", tq.size(), 0);
        end
        idle(1);
        exp_px.push_back(16'h0051); exp_px.push_back(16'h0000);
        chk_px("rst_px");
        push_frame(16'h0061);
        idle(2);
        run_frame();
        exp_seq(16'h0061, 8);
        chk_px("rst_relock_px");
        chk("rst_relock_done", fd_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
